// File: rtl/aes_inv_round_core.sv
//==============================================================================
// Module   : aes_inv_round_core
// Purpose  : Iterative AES-128 inverse round: AddRoundKey, then InvMixColumns
//            one column per cycle, then InvShiftRows, over a valid/ready pair.
//            Optional final-round bypass is enabled with AES_INV_FINAL_EN.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module aes_inv_round_core (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [0:127] state_in,
    input  logic [0:127] round_key,
`ifdef AES_INV_FINAL_EN
    input  logic         final_round,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [0:127] state_out,
    output logic         busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MIX  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t       r_state;
    logic [1:0]   r_col;
    logic [0:127] r_work;
    logic         r_in_ready;
    logic         r_out_valid;
    logic         r_busy;
`ifdef AES_INV_FINAL_EN
    logic         r_final;
`endif

    logic [0:31]  w_col_in;
    logic [0:31]  w_col_out;
    logic [0:127] w_shifted;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // Coefficients built from a, 2a, 4a, 8a: 09=8+1, 0b=8+2+1, 0d=8+4+1, 0e=8+4+2
    function automatic logic [0:31] inv_mix_col(input logic [0:31] c);
        logic [7:0] a  [4];
        logic [7:0] x2 [4];
        logic [7:0] x4 [4];
        logic [7:0] x8 [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        for (int i = 0; i < 4; i++) begin
            a[i]  = c[8*i +: 8];
            x2[i] = xtime(a[i]);
            x4[i] = xtime(x2[i]);
            x8[i] = xtime(x4[i]);
            m9[i] = x8[i] ^ a[i];
            mb[i] = x8[i] ^ x2[i] ^ a[i];
            md[i] = x8[i] ^ x4[i] ^ a[i];
            me[i] = x8[i] ^ x4[i] ^ x2[i];
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    assign w_col_in  = r_work[{r_col, 5'd0} +: 32];
    assign w_col_out = inv_mix_col(w_col_in);

    // out(r,c) = work(r,(c-r) mod 4)
    for (genvar c = 0; c < 4; c++) begin : g_isr_col
        for (genvar r = 0; r < 4; r++) begin : g_isr_row
            assign w_shifted[8*(4*c+r) +: 8] = r_work[8*(4*((c-r+4)%4)+r) +: 8];
        end
    end

`ifdef AES_INV_FINAL_EN
    assign state_out = r_final ? r_work : w_shifted;
`else
    assign state_out = w_shifted;
`endif

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_col       <= 2'd0;
            r_work      <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
`ifdef AES_INV_FINAL_EN
            r_final     <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_work     <= state_in ^ round_key;
                        r_col      <= 2'd0;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
`ifdef AES_INV_FINAL_EN
                        r_final    <= final_round;
                        if (final_round) begin
                            r_state     <= S_DONE;
                            r_out_valid <= 1'b1;
                        end else begin
                            r_state     <= S_MIX;
                        end
`else
                        r_state    <= S_MIX;
`endif
                    end
                end
                S_MIX: begin
                    r_work[{r_col, 5'd0} +: 32] <= w_col_out;
                    r_col <= r_col + 2'd1;
                    if (r_col == 2'd3) begin
                        r_state     <= S_DONE;
                        r_out_valid <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state     <= S_IDLE;
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_aes_inv_round_core.sv
//==============================================================================
// Module   : tb_aes_inv_round_core
// Purpose  : Directed self-checking bench for aes_inv_round_core (AES_INV_FINAL_EN aware).
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_aes_inv_round_core;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [0:127] state_in;
    logic [0:127] round_key;
    logic         out_valid;
    logic         out_ready;
    logic [0:127] state_out;
    logic         busy;
`ifdef AES_INV_FINAL_EN
    logic         final_round;
`endif

    int n_checks;
    int n_fail;

    aes_inv_round_core dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .state_in  (state_in),
        .round_key (round_key),
`ifdef AES_INV_FINAL_EN
        .final_round(final_round),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .state_out (state_out),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Accept one block from IDLE, wait for DONE, check latency and result, then hand it off.
    task automatic run_block(input string tag, input logic [127:0] s, input logic [127:0] k,
                             input logic [127:0] exp, input int exp_lat);
        int lat;
        state_in  = s;
        round_key = k;
        in_valid  = 1'b1;
        step();
        in_valid  = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            step();
            lat++;
        end
        chk({tag, "_latency"}, 128'(lat), 128'(exp_lat));
        chk({tag, "_data"}, state_out, exp);
        chk({tag, "_in_ready_low"}, 128'(in_ready), 128'd0);
        out_ready = 1'b1;
        step();
        chk({tag, "_back_to_idle"}, 128'(in_ready), 128'd1);
    endtask

    localparam logic [127:0] C_FIPS_IN  = {4{32'h8e4da1bc}};
    localparam logic [127:0] C_FIPS_OUT = {4{32'hdb135345}};
    localparam logic [127:0] C_KEY_A    = 128'h0123456789abcdeffedcba9876543210;

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        state_in  = '0;
        round_key = '0;
`ifdef AES_INV_FINAL_EN
        final_round = 1'b0;
`endif
        step();
        step();
        chk("rst_in_ready",  128'(in_ready),  128'd1);
        chk("rst_out_valid", 128'(out_valid), 128'd0);
        chk("rst_busy",      128'(busy),      128'd0);
        chk("rst_state_out", state_out,       128'd0);

        // Reset with in_valid asserted must not accept anything
        in_valid = 1'b1;
        state_in = C_FIPS_IN;
        step();
        step();
        rst      = 1'b0;
        in_valid = 1'b0;
        chk("rst_iv_in_ready",  128'(in_ready), 128'd1);
        chk("rst_iv_busy",      128'(busy),     128'd0);
        chk("rst_iv_state_out", state_out,      128'd0);
        step();
        chk("post_rst_idle", 128'(busy), 128'd0);

        run_block("fips", C_FIPS_IN, 128'd0, C_FIPS_OUT, 4);
        run_block("rowperm", 128'h00000000_11111111_22222222_33333333, 128'd0,
                  128'h00332211_11003322_22110033_33221100, 4);
        run_block("ark_zero", C_KEY_A, C_KEY_A, 128'd0, 4);
        run_block("ark_ones", 128'd0, {4{32'h01010101}}, {4{32'h01010101}}, 4);
        run_block("fips_keyed", C_FIPS_IN ^ C_KEY_A, C_KEY_A, C_FIPS_OUT, 4);
        // Single mixed column in column 0 / column 2 exposes column order and row rotation
        run_block("col0", {32'h8e4da1bc, 96'd0}, 128'd0,
                  128'hdb000000_00130000_00005300_00000045, 4);
        run_block("col2", {64'd0, 32'h8e4da1bc, 32'd0}, 128'd0,
                  128'h00005300_00000045_db000000_00130000, 4);

        // Backpressure: hold DONE for 10 cycles with a competing in_valid
        out_ready = 1'b0;
        state_in  = C_FIPS_IN;
        round_key = '0;
        in_valid  = 1'b1;
        step();
        in_valid  = 1'b0;
        for (int i = 0; i < 20 && !out_valid; i++) step();
        chk("bp_reached_done", 128'(out_valid), 128'd1);
        in_valid  = 1'b1;
        state_in  = C_KEY_A;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("bp_hold_data",      state_out,        C_FIPS_OUT);
            chk("bp_hold_in_ready",  128'(in_ready),   128'd0);
            chk("bp_hold_out_valid", 128'(out_valid),  128'd1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        chk("bp_release_idle", 128'(in_ready),  128'd1);
        chk("bp_release_ov",   128'(out_valid), 128'd0);
        run_block("after_bp", 128'h00000000_11111111_22222222_33333333, 128'd0,
                  128'h00332211_11003322_22110033_33221100, 4);

        // Reset on the second MIX cycle discards the block
        state_in  = C_FIPS_IN;
        round_key = C_KEY_A;
        in_valid  = 1'b1;
        step();
        in_valid  = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_in_ready",  128'(in_ready),  128'd1);
        chk("midrst_busy",      128'(busy),      128'd0);
        chk("midrst_out_valid", 128'(out_valid), 128'd0);
        chk("midrst_state_out", state_out,       128'd0);
        run_block("after_midrst", C_FIPS_IN, 128'd0, C_FIPS_OUT, 4);

`ifdef AES_INV_FINAL_EN
        final_round = 1'b1;
        run_block("final", C_FIPS_IN, C_KEY_A, C_FIPS_IN ^ C_KEY_A, 0);
        final_round = 1'b0;
        run_block("after_final", C_FIPS_IN, 128'd0, C_FIPS_OUT, 4);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
